// File: rtl/mem_bus_pkg.sv
// Shared constants for the single-port 64-bit bus memory slave.
// State codes are plain localparams so older flows can consume the encoding directly.
package mem_bus_pkg;

    localparam int unsigned WORD_W     = 64;
    localparam int unsigned BYTE_SHIFT = 3;
    localparam int unsigned ST_W       = 3;

    // Read data returned for out-of-range accesses
    localparam logic [WORD_W-1:0] ERR_FILL = {WORD_W{1'b1}};

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_WRITE = 3'd1;
    localparam logic [ST_W-1:0] ST_READ  = 3'd2;
    localparam logic [ST_W-1:0] ST_DRIVE = 3'd3;
    localparam logic [ST_W-1:0] ST_HOLD  = 3'd4;

endpackage

// File: rtl/mem_bus_ram.sv
// DEPTH x 64 synchronous RAM: one write port and one registered read port sharing an address.
// Contents are deliberately not reset.
module mem_bus_ram
    import mem_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Array write and registered read
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_slave.sv
// Memory slave for one core's 64-bit external bus: decodes nALE/nME/RnW/nOE,
// latches the byte address, auto-increments it after each completed access and
// performs synchronous reads/writes on an internal word array.
// Optional feature: define MEM_BUS_ERR_EN for out-of-range detection (Err/ErrCount ports).
module mem_bus_slave
    import mem_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [WORD_W-1:0] DataIn,
    output logic [WORD_W-1:0] DataOut,
    output logic              DataEn,
    input  logic              nALE,
    input  logic              nME,
    input  logic              RnW,
    input  logic              nOE,
`ifdef MEM_BUS_ERR_EN
    output logic              Err,
    output logic [7:0]        ErrCount,
`endif
    output logic              Busy
);

    localparam int unsigned IDX_MSB = AW + BYTE_SHIFT - 1;

    logic [ST_W-1:0]   state_q, state_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              den_q, den_d;
    logic              busy_q, busy_d;

    logic [AW-1:0]     idx_c;
    logic [WORD_W-1:0] addr_inc_c;
    logic              addr_bad_c;
    logic              ram_we_c;
    logic              ram_re_c;
    logic [WORD_W-1:0] ram_rdata;

    assign idx_c = addr_q[IDX_MSB:BYTE_SHIFT];

    // Next sequential word: index field wraps, upper and byte-offset bits kept
    assign addr_inc_c = {addr_q[WORD_W-1:IDX_MSB+1], AW'(idx_c + 1'b1), addr_q[BYTE_SHIFT-1:0]};

    // Next-state, address and output decode
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        den_d    = 1'b0;
        ram_we_c = 1'b0;
        ram_re_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!nALE) begin
                    addr_d = DataIn;
                end else if (!nME) begin
                    state_d = RnW ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: begin
                ram_we_c = !addr_bad_c;
                state_d  = ST_HOLD;
            end
            ST_READ: begin
                if (nME) begin
                    state_d = ST_IDLE;
                end else begin
                    ram_re_c = 1'b1;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (nME) begin
                    state_d = ST_IDLE;
                    addr_d  = addr_inc_c;
                end else begin
                    den_d  = !nOE;
                    dout_d = addr_bad_c ? ERR_FILL : ram_rdata;
                end
            end
            ST_HOLD: begin
                if (nME) begin
                    state_d = ST_IDLE;
                    addr_d  = addr_inc_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, address and registered bus outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            dout_q  <= '0;
            den_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            den_q   <= den_d;
            busy_q  <= busy_d;
        end
    end

    assign DataOut = dout_q;
    assign DataEn  = den_q;
    assign Busy    = busy_q;

    mem_bus_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (Clock),
        .we_i    (ram_we_c),
        .re_i    (ram_re_c),
        .addr_i  (idx_c),
        .wdata_i (DataIn),
        .rdata_o (ram_rdata)
    );

`ifdef MEM_BUS_ERR_EN
    logic       access_start_c;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    assign addr_bad_c     = |addr_q[WORD_W-1:IDX_MSB+1];
    assign access_start_c = (state_q == ST_IDLE) && nALE && !nME;

    // Sticky error flag and saturating count of out-of-range accesses
    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (access_start_c && addr_bad_c) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // Error registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign Err      = err_q;
    assign ErrCount = err_cnt_q;
`else
    assign addr_bad_c = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_slave.sv
// Self-checking bench for mem_bus_slave: transaction tasks derive per-cycle
// expectations (Busy, DataEn, DataOut) from bus timing rules and a word-array model.
module tb_mem_bus_slave;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [63:0] IDX_MASK = 64'((DEPTH - 1) * 8);

    logic        Clock = 1'b0;
    logic        Reset;
    logic [63:0] DataIn;
    logic [63:0] DataOut;
    logic        DataEn;
    logic        nALE, nME, RnW, nOE;
    logic        Busy;
`ifdef MEM_BUS_ERR_EN
    logic        Err;
    logic [7:0]  ErrCount;
`endif

    mem_bus_slave #(.DEPTH(DEPTH)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .DataEn   (DataEn),
        .nALE     (nALE),
        .nME      (nME),
        .RnW      (RnW),
        .nOE      (nOE),
`ifdef MEM_BUS_ERR_EN
        .Err      (Err),
        .ErrCount (ErrCount),
`endif
        .Busy     (Busy)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [63:0] m_mem [DEPTH];
    bit          m_vld [DEPTH];
    logic [63:0] m_addr;

    // Per-cycle expectations for the compare process
    bit          chk_en   = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_den  = 1'b0;
    bit          chk_dout = 1'b0;
    logic [63:0] exp_dout = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Compare DUT outputs against expectations once per cycle
    always @(negedge Clock) begin
        if (chk_en) begin
            chk("busy", 64'(Busy), 64'(exp_busy));
            chk("data_en", 64'(DataEn), 64'(exp_den));
            if (chk_dout) chk("data_out", DataOut, exp_dout);
        end
    end

    function automatic int unsigned idx_of(input logic [63:0] a);
        return int'((a & IDX_MASK) >> 3);
    endfunction

    function automatic bit is_bad(input logic [63:0] a);
`ifdef MEM_BUS_ERR_EN
        return (a >> (AW + 3)) != 64'd0;
`else
        return 1'b0;
`endif
    endfunction

    // Address after one completed access: word index advances modulo DEPTH
    function automatic logic [63:0] next_addr(input logic [63:0] a);
        return (a & ~IDX_MASK) | ((a + 64'd8) & IDX_MASK);
    endfunction

    function automatic logic [63:0] junk();
        return {$urandom(), $urandom()};
    endfunction

    task automatic clk_step(input logic b, input logic d, input bit cd, input logic [63:0] dv);
        @(posedge Clock);
        exp_busy = b;
        exp_den  = d;
        chk_dout = cd;
        exp_dout = dv;
        #1;
    endtask

    task automatic latch(input logic [63:0] a);
        nALE   = 1'b0;
        DataIn = a;
        nME    = 1'($urandom());
        RnW    = 1'($urandom());
        nOE    = 1'($urandom());
        clk_step(1'b0, 1'b0, 1'b0, '0);
        nALE   = 1'b1;
        nME    = 1'b1;
        DataIn = junk();
        m_addr = a;
    endtask

    // nME held low for len edges (len >= 2)
    task automatic write_txn(input logic [63:0] data, input int len);
        int unsigned ix = idx_of(m_addr);
        bit bad = is_bad(m_addr);
        nME = 1'b0; RnW = 1'b0; nOE = 1'($urandom()); DataIn = junk();
        for (int k = 0; k <= len; k++) begin
            if (k < len) clk_step(1'b1, 1'b0, 1'b0, '0);
            else         clk_step(1'b0, 1'b0, 1'b0, '0);
            nME    = (k + 1 < len) ? 1'b0 : 1'b1;
            RnW    = 1'($urandom());
            nOE    = 1'($urandom());
            DataIn = (k == 0) ? data : junk();
        end
        if (!bad) begin
            m_mem[ix] = data;
            m_vld[ix] = 1'b1;
        end
        m_addr = next_addr(m_addr);
    endtask

    // nME held low for len edges; len == 1 is an aborted read
    task automatic read_txn(input int len, input bit noe_low, output logic [63:0] got);
        int unsigned ix = idx_of(m_addr);
        bit bad = is_bad(m_addr);
        bit cd_ok = bad || m_vld[ix];
        logic [63:0] ev = bad ? 64'hFFFF_FFFF_FFFF_FFFF : m_mem[ix];
        logic noe_s;
        got = '0;
        nME = 1'b0; RnW = 1'b1; nOE = noe_low ? 1'b0 : 1'($urandom()); DataIn = junk();
        for (int k = 0; k <= len; k++) begin
            noe_s = nOE;
            if (k < len) clk_step(1'b1, (k >= 2) && !noe_s, (k >= 2) && cd_ok, ev);
            else         clk_step(1'b0, 1'b0, 1'b0, '0);
            if (k == 2 && len >= 3) got = DataOut;
            nME    = (k + 1 < len) ? 1'b0 : 1'b1;
            RnW    = 1'($urandom());
            nOE    = noe_low ? 1'b0 : 1'($urandom());
            DataIn = junk();
        end
        if (len >= 2) m_addr = next_addr(m_addr);
    endtask

    logic [63:0] got;
    logic [63:0] wa, wb;

    initial begin
        Reset = 1'b1; nALE = 1'b1; nME = 1'b1; RnW = 1'b1; nOE = 1'b1; DataIn = '0;
        for (int i = 0; i < int'(DEPTH); i++) m_vld[i] = 1'b0;
        m_addr = '0;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_data_out", DataOut, 64'd0);
        chk("reset_data_en", 64'(DataEn), 64'd0);
        chk("reset_busy", 64'(Busy), 64'd0);
`ifdef MEM_BUS_ERR_EN
        chk("reset_err", 64'(Err), 64'd0);
        chk("reset_err_count", 64'(ErrCount), 64'd0);
`endif
        Reset  = 1'b0;
        chk_en = 1'b1;

        // Basic write then read-back with nOE low
        latch(64'h40);
        write_txn(64'hDEADBEEF_CAFEF00D, 2);
        latch(64'h40);
        read_txn(3, 1'b1, got);
        chk("basic_read", got, 64'hDEADBEEF_CAFEF00D);

        // Auto-increment across consecutive pulses
        latch(64'h0);
        write_txn(64'd1, 2);
        write_txn(64'd2, 3);
        write_txn(64'd3, 2);
        latch(64'h0);
        read_txn(3, 1'b1, got); chk("incr_read0", got, 64'd1);
        read_txn(4, 1'b0, got); chk("incr_read1", got, 64'd2);
        read_txn(3, 1'b1, got); chk("incr_read2", got, 64'd3);

        // Index wrap from last word to word 0
        wa = 64'hA5A5_0000_1111_2222;
        wb = 64'h5A5A_3333_4444_5555;
        latch(64'h1FF8);
        write_txn(wa, 2);
        write_txn(wb, 2);
        latch(64'h1FF8);
        read_txn(3, 1'b1, got); chk("wrap_last", got, wa);
        read_txn(3, 1'b1, got); chk("wrap_first", got, wb);

        // Aborted read leaves the address alone
        latch(64'h40);
        read_txn(1, 1'b1, got);
        read_txn(3, 1'b1, got);
        chk("abort_addr_kept", got, 64'hDEADBEEF_CAFEF00D);

        // Reset asserted while driving
        latch(64'h8);
        nME = 1'b0; RnW = 1'b1; nOE = 1'b0;
        clk_step(1'b1, 1'b0, 1'b0, '0);
        clk_step(1'b1, 1'b0, 1'b0, '0);
        clk_step(1'b1, 1'b1, 1'b1, 64'd2);
        @(negedge Clock);
        #1;
        exp_busy = 1'b0; exp_den = 1'b0; chk_dout = 1'b0;
        Reset = 1'b1;
        #1;
        chk("rst_mid_data_en", 64'(DataEn), 64'd0);
        chk("rst_mid_busy", 64'(Busy), 64'd0);
        nME = 1'b1; nOE = 1'b1;
        @(posedge Clock);
        #1;
        Reset  = 1'b0;
        m_addr = '0;
        latch(64'h8);
        read_txn(3, 1'b1, got);
        chk("after_reset_read", got, 64'd2);

`ifdef MEM_BUS_ERR_EN
        latch(64'h10_0000);
        write_txn(64'h1234, 2);
        latch(64'h10_0000);
        read_txn(3, 1'b1, got);
        chk("err_read_fill", got, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("err_flag", 64'(Err), 64'd1);
        chk("err_count2", 64'(ErrCount), 64'd2);
        for (int i = 0; i < 300; i++) write_txn(junk(), 2);
        chk("err_count_sat", 64'(ErrCount), 64'd255);
        chk("err_flag_sticky", 64'(Err), 64'd1);
`endif

        // Randomized traffic against the model
        latch(64'h0);
        for (int n = 0; n < 200; n++) begin
            int unsigned op = $urandom_range(0, 9);
            if (op < 2) begin
`ifdef MEM_BUS_ERR_EN
                latch(64'($urandom_range(0, DEPTH * 8 - 1)));
`else
                latch(junk());
`endif
            end else if (op < 6) begin
                write_txn(junk(), int'($urandom_range(2, 4)));
            end else begin
                read_txn(int'($urandom_range(1, 5)), 1'($urandom()), got);
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_slave.md
# mem_bus_slave

Single-port memory slave for one core's 64-bit external bus: decodes the core-side strobes (nALE, nME, RnW, nOE), latches addresses, and performs synchronous reads and writes against an internal word array. It sits directly downstream of a core bus pin group and returns read data to the CPU's tristate data pins. Four instances, one per core bus, form the quad-core memory system.

## Interface
- DEPTH, 1024, number of 64-bit words; power of two
- AW, $clog2(DEPTH), word-index width
- Clock  input  1  rising-edge system clock
- Reset  input  1  asynchronous, active-high reset
- DataIn  input  64  resolved bus value: address during nALE, write data during write
- DataOut  output  64  read data for the bus
- DataEn  output  1  high = slave drives bus; pad logic applies tristate
- nALE  input  1  active-low address latch enable
- nME  input  1  active-low memory enable (cycle strobe)
- RnW  input  1  1 = read, 0 = write; sampled with nME
- nOE  input  1  active-low output enable for reads
- Busy  output  1  high while a cycle is in progress (state not IDLE)
- Err, ErrCount[7:0]  output  present only with MEM_BUS_ERR_EN (see Configuration)

## Operation
- All strobes sampled at rising Clock; no combinational path from inputs to outputs.
- Address: byte address on DataIn; word index = DataIn[AW+2:3]; bits [2:0] ignored. Full address kept in 64-bit AddrReg for range check.
- States: IDLE, WRITE, READ, DRIVE, HOLD.
- IDLE: nALE low -> AddrReg <= DataIn, stay IDLE. nALE takes priority: nME ignored while nALE low. nME low with nALE high -> RnW=0: WRITE; RnW=1: READ.
- WRITE: mem[idx] <= DataIn at that edge (DataIn sampled one cycle after nME first seen low); -> HOLD.
- READ: RAM read issued; DataOut register loaded at next edge -> DRIVE.
- DRIVE: DataEn = !nOE (registered: follows nOE with one-cycle lag); nME high -> IDLE, DataEn 0.
- HOLD: wait for nME high -> IDLE. One access per nME assertion.
- Auto-increment: on every return to IDLE from a completed access, AddrReg += 8; consecutive nME pulses without nALE access sequential words. Index wraps DEPTH-1 -> 0.
- Abort: nME high in READ -> IDLE next edge, no drive, AddrReg not incremented.
- nOE low during write or IDLE: ignored; DataEn stays 0.
- RnW sampled only on entry from IDLE; changes mid-cycle ignored.

## Timing
- Reset values: DataOut 0, DataEn 0, Busy 0, AddrReg 0, state IDLE, Err 0, ErrCount 0. RAM contents not reset.
- Reset asserted mid-cycle: state IDLE, DataEn 0 immediately (async); in-flight write not performed if Reset precedes the WRITE edge.
- Write: nME sampled low at edge E -> RAM updated at E+1.
- Read: nME sampled low at E -> DataOut valid after E+2; DataEn high after first edge >= E+2 at which nOE sampled low.
- Minimum cycle: nME low 3 edges for read, 2 for write; one idle edge between cycles.

## Configuration
- MEM_BUS_ERR_EN defined: address with any bit above AW+2 set is out of range; writes discarded, reads return 64'hFFFF_FFFF_FFFF_FFFF; Err sticky high until Reset; ErrCount increments per out-of-range access, saturating at 255. Ports Err and ErrCount exist.
- Undefined: no range check, upper bits ignored (alias), ports absent.

## Structure
- Package mem_bus_pkg: state enum (IDLE, WRITE, READ, DRIVE, HOLD), WORD_W=64, BYTE_SHIFT=3, ERR_FILL constant.
- Sub-module mem_bus_ram: DEPTH x 64 synchronous RAM, one write port, one registered read port.
- Top holds FSM, address register/incrementer, drive enable, error logic.

## Test plan
- Reset, nALE low with DataIn=0x40, write 0xDEADBEEF_CAFEF00D, then read 0x40 with nOE low -> DataOut=0xDEADBEEF_CAFEF00D, DataEn high 2 edges after nME.
- nALE at 0x0, three write pulses 1,2,3 without nALE, then reads at 0x0,0x8,0x10 -> 1,2,3 (auto-increment).
- DEPTH=1024, nALE 0x1FF8, two writes A,B -> mem[1023]=A, mem[0]=B (wrap).
- Read with nME released after 1 edge -> DataEn never high, Busy 0 next edge, AddrReg unchanged.
- Reset asserted during DRIVE -> DataEn 0 immediately; previously written data still readable afterwards.
- MEM_BUS_ERR_EN: write to 0x10_0000 then read it -> data 0xFFFF_FFFF_FFFF_FFFF, Err 1, ErrCount 2; 300 bad accesses -> ErrCount 255.
